// File: rtl/lock_unlock_ctrl.sv
// Lock-on-reset initiator: grants a timed unlock strobe after a correct key is
// accepted over a valid/ready handshake. Wrong keys trigger a cooldown, and too
// many of them trigger a lockout that only reset clears. All outputs registered.
module lock_unlock_ctrl #(
  parameter int unsigned             KEY_W         = 8,
  parameter logic        [KEY_W-1:0] KEY           = 8'hA5,
  parameter int unsigned             UNLOCK_CYCLES = 4,   // 0 = hold until relock
  parameter int unsigned             COOLDOWN      = 3,   // must be >= 1
  parameter int unsigned             MAX_FAILS     = 3,   // must be >= 1
  parameter int unsigned             FAIL_W        = 2    // must hold MAX_FAILS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              key_valid_i,
  input  logic [KEY_W-1:0]  key_data_i,
  input  logic              relock_i,
  output logic              key_ready_o,
  output logic              unlock_o,
  output logic              lockout_o,
  output logic [FAIL_W-1:0] fail_cnt_o
);

  // One timer serves both the unlock window and the cooldown.
  localparam int unsigned TimerMax = (UNLOCK_CYCLES > COOLDOWN) ? UNLOCK_CYCLES : COOLDOWN;
  localparam int unsigned TimerW   = (TimerMax < 2) ? 1 : $clog2(TimerMax + 1);

  typedef enum logic [1:0] {
    StLocked   = 2'd0,
    StCooldown = 2'd1,
    StUnlocked = 2'd2,
    StLockout  = 2'd3
  } state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic [FAIL_W-1:0]   fail_cnt_q;
  logic                key_ready_q;
  logic                unlock_q;
  logic                lockout_q;

  logic                accept;
  logic [FAIL_W-1:0]   fail_inc;
  logic                unlock_expire;

  assign accept        = key_valid_i & key_ready_q;
  assign fail_inc      = fail_cnt_q + FAIL_W'(1);
  // With UNLOCK_CYCLES == 0 the window never times out.
  assign unlock_expire = (UNLOCK_CYCLES != 0) && (timer_q == TimerW'(1));

  // State machine with registered outputs; reset dominates every input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StLocked;
      timer_q     <= '0;
      fail_cnt_q  <= '0;
      key_ready_q <= 1'b1;
      unlock_q    <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      case (state_q)
        StLocked: begin
          if (accept) begin
            key_ready_q <= 1'b0;
            if (key_data_i == KEY) begin
              state_q    <= StUnlocked;
              unlock_q   <= 1'b1;
              fail_cnt_q <= '0;
              timer_q    <= TimerW'(UNLOCK_CYCLES);
            end else if (fail_inc == FAIL_W'(MAX_FAILS)) begin
              state_q    <= StLockout;
              lockout_q  <= 1'b1;
              fail_cnt_q <= fail_inc;
            end else begin
              state_q    <= StCooldown;
              fail_cnt_q <= fail_inc;
              timer_q    <= TimerW'(COOLDOWN);
            end
          end
        end
        StCooldown: begin
          // relock is deliberately ignored here.
          if (timer_q <= TimerW'(1)) begin
            state_q     <= StLocked;
            key_ready_q <= 1'b1;
            timer_q     <= '0;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StUnlocked: begin
          if (relock_i || unlock_expire) begin
            state_q     <= StLocked;
            unlock_q    <= 1'b0;
            key_ready_q <= 1'b1;
            timer_q     <= '0;
          end else if (UNLOCK_CYCLES != 0) begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StLockout: begin
          unlock_q    <= 1'b0;
          key_ready_q <= 1'b0;
          lockout_q   <= 1'b1;
        end
        default: begin
          state_q     <= StLocked;
          unlock_q    <= 1'b0;
          key_ready_q <= 1'b1;
          timer_q     <= '0;
        end
      endcase
    end
  end

  assign key_ready_o = key_ready_q;
  assign unlock_o    = unlock_q;
  assign lockout_o   = lockout_q;
  assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: tb/tb_lock_unlock_ctrl.sv
// Bench for lock_unlock_ctrl: directed scenarios plus random traffic, all checked
// against a deadline-based reference model (cycle numbers, not states).
module tb_lock_unlock_ctrl;

  localparam int unsigned KeyW   = 8;
  localparam logic [7:0]  Key    = 8'hA5;
  localparam int          Unlock = 4;
  localparam int          Cool   = 3;
  localparam int          MaxF   = 3;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       key_valid_i = 1'b0;
  logic [7:0] key_data_i = '0;
  logic       relock_i = 1'b0;
  logic       key_ready_o;
  logic       unlock_o;
  logic       lockout_o;
  logic [1:0] fail_cnt_o;

  lock_unlock_ctrl #(
    .KEY_W        (KeyW),
    .KEY          (Key),
    .UNLOCK_CYCLES(Unlock),
    .COOLDOWN     (Cool),
    .MAX_FAILS    (MaxF),
    .FAIL_W       (2)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .key_valid_i(key_valid_i),
    .key_data_i (key_data_i),
    .relock_i   (relock_i),
    .key_ready_o(key_ready_o),
    .unlock_o   (unlock_o),
    .lockout_o  (lockout_o),
    .fail_cnt_o (fail_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: current cycle index plus the cycles at which the unlock
  // window and the cooldown end.
  int m_cur = 0;
  int m_unlock_end = 0;
  int m_cool_end = 0;
  int m_fails = 0;
  bit m_lockout = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_unlocked();
    return !m_lockout && (m_cur < m_unlock_end);
  endfunction

  function automatic bit m_ready();
    return !m_lockout && (m_cur >= m_unlock_end) && (m_cur >= m_cool_end);
  endfunction

  // Apply inputs for one cycle, advance the model across the edge, then compare.
  task automatic step(input bit v, input logic [7:0] d, input bit rl, input bit rst);
    key_valid_i = v;
    key_data_i  = d;
    relock_i    = rl;
    reset_i     = rst;
    @(posedge clk_i);
    if (rst) begin
      m_lockout = 1'b0; m_fails = 0; m_unlock_end = 0; m_cool_end = 0;
    end else if (m_lockout) begin
      // absorbing
    end else if (m_unlocked()) begin
      if (rl) m_unlock_end = m_cur + 1;
    end else if (m_ready() && v) begin
      if (d == Key) begin
        m_fails = 0;
        m_unlock_end = m_cur + 1 + Unlock;
      end else begin
        m_fails++;
        if (m_fails == MaxF) m_lockout = 1'b1;
        else m_cool_end = m_cur + 1 + Cool;
      end
    end
    m_cur++;
    #1;
    check_eq("unlock",    int'(unlock_o),    int'(m_unlocked()));
    check_eq("key_ready", int'(key_ready_o), int'(m_ready()));
    check_eq("lockout",   int'(lockout_o),   int'(m_lockout));
    check_eq("fail_cnt",  int'(fail_cnt_o),  m_fails);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  int ucnt;

  initial begin
    // 1: reset for two cycles then release
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("rst_ready", int'(key_ready_o), 1);
    check_eq("rst_unlock", int'(unlock_o), 0);
    idle(2);

    // 2: good key, unlock must last exactly four cycles
    step(1'b1, Key, 1'b0, 1'b0);
    ucnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (unlock_o) ucnt++;
      idle(1);
    end
    check_eq("unlock_len", ucnt, 4);
    check_eq("ready_back", int'(key_ready_o), 1);

    // 3: wrong key, cooldown, then good key clears fail count
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("fail_one", int'(fail_cnt_o), 1);
    for (int i = 0; i < Cool; i++) step(1'b1, Key, 1'b1, 1'b0);
    step(1'b1, Key, 1'b0, 1'b0);
    check_eq("unlock_after_cool", int'(unlock_o), 1);
    idle(5);

    // 4: three wrong keys -> lockout, good key ignored, reset clears
    for (int k = 0; k < MaxF; k++) begin
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      idle(Cool);
    end
    check_eq("lockout_set", int'(lockout_o), 1);
    step(1'b1, Key, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("lockout_no_unlock", int'(unlock_o), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // 5: relock in second unlocked cycle; key_valid while unlocked has no effect
    step(1'b1, Key, 1'b0, 1'b0);
    step(1'b1, Key, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("relock_drop", int'(unlock_o), 0);
    idle(1);
    step(1'b1, Key, 1'b0, 1'b0);
    ucnt = 1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, Key, 1'b0, 1'b0);
      if (unlock_o) ucnt++;
      if (!unlock_o) break;
    end
    check_eq("no_extend", ucnt, 4);
    idle(6);

    // 6: reset mid-unlock and mid-cooldown
    step(1'b1, Key, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("rst_mid_unlock", int'(unlock_o), 0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("rst_mid_cool", int'(key_ready_o), 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 9) < 4) ? Key : 8'($urandom);
      step(bit'($urandom_range(0, 1)), d, $urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
